// File: rtl/pb_rect_fill.sv
// pb_rect_fill: fills a clamped rectangle of the 160x120 pixel buffer with one colour, one pixel per clock in raster order.
module pb_rect_fill #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 4
) (
  input  logic              VGA_CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [7:0]        X0,
  input  logic [7:0]        X1,
  input  logic [6:0]        Y0,
  input  logic [6:0]        Y1,
  input  logic [DATA_W-1:0] COLOUR,
  output logic [ADDR_W-1:0] PB_WA,
  output logic [DATA_W-1:0] PB_DATA,
  output logic              PB_WE,
  output logic              BUSY,
  output logic              DONE
);
  typedef enum logic [1:0] {IDLE, LOAD, FILL} state_t;
  state_t state;
  logic [7:0] x0_q, x1_q, xmin, xmax, x;
  logic [6:0] y0_q, y1_q, ymax, y;
  logic [DATA_W-1:0] colour_q;
  logic [ADDR_W-1:0] rowbase;
  logic [7:0] lx_min, lx_max, cx_max;
  logic [6:0] ly_min, ly_max, cy_max;
  logic empty;
  logic [ADDR_W-1:0] row0;
  always_comb begin
    lx_min = x0_q < x1_q ? x0_q : x1_q;
    lx_max = x0_q < x1_q ? x1_q : x0_q;
    ly_min = y0_q < y1_q ? y0_q : y1_q;
    ly_max = y0_q < y1_q ? y1_q : y0_q;
    cx_max = lx_max > 8'(H_RES - 1) ? 8'(H_RES - 1) : lx_max;
    cy_max = ly_max > 7'(V_RES - 1) ? 7'(V_RES - 1) : ly_max;
    empty  = lx_min > 8'(H_RES - 1) || ly_min > 7'(V_RES - 1);
    row0   = ADDR_W'(ly_min) * ADDR_W'(H_RES);
  end
  // Ending in IDLE with BUSY still set is what produces the DONE pulse, for both filled and empty rectangles.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      PB_WA    <= '0;
      PB_DATA  <= '0;
      PB_WE    <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      colour_q <= '0;
      xmin     <= '0;
      xmax     <= '0;
      ymax     <= '0;
      x        <= '0;
      y        <= '0;
      rowbase  <= '0;
    end else begin
      PB_WE <= 1'b0;
      DONE  <= 1'b0;
      case (state)
        IDLE: begin
          if (BUSY) begin
            BUSY <= 1'b0;
            DONE <= 1'b1;
          end else if (START) begin
            x0_q     <= X0;
            x1_q     <= X1;
            y0_q     <= Y0;
            y1_q     <= Y1;
            colour_q <= COLOUR;
            BUSY     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          xmin    <= lx_min;
          xmax    <= cx_max;
          ymax    <= cy_max;
          x       <= lx_min;
          y       <= ly_min;
          rowbase <= row0;
          state   <= empty ? IDLE : FILL;
        end
        FILL: begin
          PB_WA   <= rowbase + ADDR_W'(x);
          PB_DATA <= colour_q;
          PB_WE   <= 1'b1;
          if (x < xmax) x <= x + 8'd1;
          else if (y < ymax) begin
            x       <= xmin;
            y       <= y + 7'd1;
            rowbase <= rowbase + ADDR_W'(H_RES);
          end else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
